// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and sizing helpers for the digit scan controller.
// Optional DIGIT_MASK_EN feature is handled in digit_scan_ctrl.
package scan_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

   localparam int SEL_W = 3;
   localparam int NIB_W = 4;
   localparam int MAX_DIGITS = 8;

   function automatic int timer_width(input int clk_div, input int blank_cycles);
      int m;
      m = (clk_div > blank_cycles) ? clk_div : blank_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/digit_scan_ctrl_timer.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
module scan_timer #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign tc_o = (count_q == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display scanner driving a 3:8 decoder with blanking between slots.
// Define DIGIT_MASK_EN to add mask_i, which suppresses en_o for masked digits.
module digit_scan_ctrl
   import scan_pkg::*;
#(
   parameter int CLK_DIV      = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int NUM_DIGITS   = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      run_i,
   input  logic [4*NUM_DIGITS-1:0]   digit_data_i,
`ifdef DIGIT_MASK_EN
   input  logic [NUM_DIGITS-1:0]     mask_i,
`endif
   output logic [SEL_W-1:0]          sel_o,
   output logic                      en_o,
   output logic [NIB_W-1:0]          nibble_o,
   output logic                      frame_o
);

   localparam int TW = timer_width(CLK_DIV, BLANK_CYCLES);
   localparam bit NO_BLANK = (BLANK_CYCLES == 0);
   localparam int C_LOAD = CLK_DIV - 1;
   localparam int B_LOAD = NO_BLANK ? 0 : BLANK_CYCLES - 1;

   state_t            state_q;
   logic [SEL_W-1:0]  sel_q;
   logic              en_q;
   logic [NIB_W-1:0]  nib_q;
   logic              frame_q;

   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_tc;

   // Padded to the full decoder range so a 3-bit select always indexes cleanly.
   logic [NIB_W-1:0]       nib_arr [MAX_DIGITS];
   logic [MAX_DIGITS-1:0]  digit_on;

   generate
      for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_digit
         if (gi < NUM_DIGITS) begin : g_used
            assign nib_arr[gi] = digit_data_i[NIB_W*gi +: NIB_W];
`ifdef DIGIT_MASK_EN
            assign digit_on[gi] = ~mask_i[gi];
`else
            assign digit_on[gi] = 1'b1;
`endif
         end else begin : g_unused
            assign nib_arr[gi]  = '0;
            assign digit_on[gi] = 1'b0;
         end
      end
   endgenerate

   logic              sel_last;
   logic [SEL_W-1:0]  sel_inc;

   assign sel_last = (sel_q == SEL_W'(NUM_DIGITS - 1));
   assign sel_inc  = sel_last ? '0 : sel_q + 1'b1;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TW'(C_LOAD);
      case (state_q)
         IDLE: begin
            if (run_i) begin
               tmr_load = 1'b1;
               tmr_val  = NO_BLANK ? TW'(C_LOAD) : TW'(B_LOAD);
            end
         end
         BLANK: begin
            if (run_i && tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(C_LOAD);
            end
         end
         ON: begin
            if (run_i && tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = NO_BLANK ? TW'(C_LOAD) : TW'(B_LOAD);
            end
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   scan_timer #(.W(TW)) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .tc_o       (tmr_tc)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         nib_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (run_i) begin
                  sel_q   <= '0;
                  nib_q   <= nib_arr[0];
                  state_q <= NO_BLANK ? ON : BLANK;
                  en_q    <= NO_BLANK && digit_on[0];
               end
            end
            BLANK: begin
               if (!run_i) begin
                  state_q <= IDLE;
                  sel_q   <= '0;
                  en_q    <= 1'b0;
               end else if (tmr_tc) begin
                  state_q <= ON;
                  en_q    <= digit_on[sel_q];
               end
            end
            ON: begin
               if (!run_i) begin
                  state_q <= IDLE;
                  sel_q   <= '0;
                  en_q    <= 1'b0;
               end else if (tmr_tc) begin
                  sel_q   <= sel_inc;
                  nib_q   <= nib_arr[sel_inc];
                  frame_q <= sel_last;
                  state_q <= NO_BLANK ? ON : BLANK;
                  en_q    <= NO_BLANK && digit_on[sel_inc];
               end else begin
                  // Mask is re-evaluated every cycle of the lit period.
                  en_q <= digit_on[sel_q];
               end
            end
            default: begin
               state_q <= IDLE;
               en_q    <= 1'b0;
            end
         endcase
      end
   end

   assign sel_o    = sel_q;
   assign en_o     = en_q;
   assign nibble_o = nib_q;
   assign frame_o  = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: two configurations share stimulus, each
// with its own arithmetic reference model, expectation queue and monitor.
module tb_digit_scan_ctrl;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic [3:0] nib;
      logic       frame;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        run;
   logic [31:0] data;
   logic [7:0]  mask;

   int n_tests;
   int n_fail;
   int cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
         localparam int ND = (gi == 0) ? 8 : 3;
         localparam int BK = (gi == 0) ? 2 : 0;
         localparam int CD = 4;

         logic [2:0] sel;
         logic       en;
         logic [3:0] nib;
         logic       frame;

         digit_scan_ctrl #(
            .CLK_DIV      (CD),
            .BLANK_CYCLES (BK),
            .NUM_DIGITS   (ND)
         ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .run_i        (run),
            .digit_data_i (data[4*ND-1:0]),
`ifdef DIGIT_MASK_EN
            .mask_i       (mask[ND-1:0]),
`endif
            .sel_o        (sel),
            .en_o         (en),
            .nibble_o     (nib),
            .frame_o      (frame)
         );

         // Reference: cycles since scan start -> slot, phase within slot, digit.
         int         m_c;
         bit         m_act;
         bit         m_on;
         bit         m_en;
         bit         m_frame;
         logic [2:0] m_sel;
         logic [3:0] m_nib;
         exp_t       q[$];

         initial begin
            m_c = 0; m_act = 0; m_on = 0; m_en = 0; m_frame = 0;
            m_sel = '0; m_nib = '0;
            forever begin
               int p;
               int pos;
               int dig;
               bit mbit;
               @(posedge clk);
               p = BK + CD;
               if (rst) begin
                  m_act = 0; m_c = 0; m_nib = '0;
               end else if (!m_act) begin
                  if (run) begin
                     m_act = 1; m_c = 0; m_nib = data[3:0];
                  end
               end else if (!run) begin
                  m_act = 0;
               end else begin
                  m_c++;
                  if (m_c % p == 0) begin
                     dig = (m_c / p) % ND;
                     m_nib = data[4*dig +: 4];
                  end
               end
               if (m_act) begin
                  pos   = m_c % p;
                  dig   = (m_c / p) % ND;
                  m_sel = 3'(dig);
`ifdef DIGIT_MASK_EN
                  mbit = mask[dig];
`else
                  mbit = 1'b0;
`endif
                  m_on    = (pos >= BK);
                  m_en    = m_on && !mbit;
                  m_frame = (m_c > 0) && (m_c % (ND * p) == 0);
               end else begin
                  m_sel = '0; m_on = 0; m_en = 0; m_frame = 0;
               end
               q.push_back('{sel: m_sel, en: m_en, nib: m_nib, frame: m_frame});
            end
         end

         initial begin
            forever begin
               exp_t e;
               logic [7:0] got_dec;
               logic [7:0] exp_dec;
               @(negedge clk);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  got_dec = en ? (8'd1 << sel) : 8'd0;
                  exp_dec = e.en ? (8'd1 << e.sel) : 8'd0;
                  n_tests++;
                  if ({sel, en, nib, frame} !== {e.sel, e.en, e.nib, e.frame} || got_dec !== exp_dec) begin
                     n_fail++;
                     $display("[TB] FAIL cfg%0d_outputs cyc=%0d got sel=%0d en=%b nib=%h frame=%b dec=%b want sel=%0d en=%b nib=%h frame=%b dec=%b",
                              gi, cyc, sel, en, nib, frame, got_dec, e.sel, e.en, e.nib, e.frame, exp_dec);
                  end
                  if (e.frame)
                     $display("[TB] cfg%0d frame start at cyc=%0d", gi, cyc);
               end
            end
         end
      end
   endgenerate

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Waits (bounded) for cfg0 to be in the lit phase of slot s.
   task automatic wait_on_slot(input int s, input string what);
      int k;
      for (k = 0; k < 200; k++) begin
         if (g_cfg[0].m_act && g_cfg[0].m_on && g_cfg[0].m_sel == 3'(s)) break;
         tick();
      end
      n_tests++;
      if (k >= 200) begin
         n_fail++;
         $display("[TB] FAIL wait_%s timed out waiting for slot %0d", what, s);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst  = 1'b1;
      run  = 1'b0;
      data = 32'h7654_3210;
`ifdef DIGIT_MASK_EN
      mask = 8'b0000_0100;
`else
      mask = 8'h00;
`endif
      tick(3);
      rst = 1'b0;
      tick(5);

      run = 1'b1;
      tick(60);
      wait_on_slot(2, "midslot2");
      data = 32'hFFFF_FFFF;
      tick(20);
      data = 32'h7654_3210;
      tick(60);

      wait_on_slot(5, "drop_run");
      run = 1'b0;
      tick(3);
      run = 1'b1;
      tick(30);

      wait_on_slot(3, "reset");
      tick(1);
      run = 1'b0;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({g_cfg[0].sel, g_cfg[0].en, g_cfg[0].nib, g_cfg[0].frame} !== 9'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset_cfg0 got %h want 0",
                  {g_cfg[0].sel, g_cfg[0].en, g_cfg[0].nib, g_cfg[0].frame});
      end
      n_tests++;
      if ({g_cfg[1].sel, g_cfg[1].en, g_cfg[1].nib, g_cfg[1].frame} !== 9'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset_cfg1 got %h want 0",
                  {g_cfg[1].sel, g_cfg[1].en, g_cfg[1].nib, g_cfg[1].frame});
      end
      tick(2);
      rst = 1'b0;
      tick(8);
      run = 1'b1;
      tick(100);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 63) == 0) run = ~run;
         if ($urandom_range(0, 7) == 0) data = $urandom;
`ifdef DIGIT_MASK_EN
         if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
`endif
         tick();
      end

      run = 1'b0;
      tick(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
